// File: rtl/rv_boot_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// master = stream source / memory side, slave = the loader itself.
interface rv_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_boot_loader.sv
// Framed byte-stream program loader: assembles LE words, writes memory from address 0,
// and holds the core in reset until a checksum-verified image has been written.
module rv_boot_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  rv_boot_loader_if.slave   bus,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StError
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           rem_q, rem_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [7:0]            csum_q, csum_d;
  logic [31:0]           tmo_q, tmo_d;
  logic [15:0]           words_q, words_d;

  logic        accept;
  logic [15:0] len_full;

  assign busy     = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCsum);
  assign accept   = bus.in_valid & busy;
  assign len_full = {bus.in_data, len_lo_q};

  assign bus.in_ready  = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst      = (state_q != StDone);
  assign done          = (state_q == StDone);
  assign error         = (state_q == StError);
  assign words_loaded  = words_q;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    ptr_d    = ptr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    csum_d   = csum_q;
    tmo_d    = tmo_q;
    words_d  = words_q;

    // Pointer and count advance at the end of the write cycle.
    if (we_q) begin
      ptr_d   = ptr_q + 1'b1;
      words_d = words_q + 16'd1;
    end

    if (busy) begin
      tmo_d = accept ? 32'd0 : tmo_q + 32'd1;
    end

    if (accept && state_q != StCsum) begin
      csum_d = csum_q + bus.in_data;
    end

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StLenLo;
          csum_d  = 8'd0;
          tmo_d   = 32'd0;
          words_d = 16'd0;
          ptr_d   = '0;
          bcnt_d  = 2'd0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_lo_d = bus.in_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          rem_d  = len_full;
          bcnt_d = 2'd0;
          if (32'(len_full) > MAX_WORDS) state_d = StError;
          else if (len_full == 16'd0)    state_d = StCsum;
          else                           state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0:    asm_d[7:0]   = bus.in_data;
            2'd1:    asm_d[15:8]  = bus.in_data;
            2'd2:    asm_d[23:16] = bus.in_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = {bus.in_data, asm_q};
              rem_d   = rem_q - 16'd1;
              if (rem_q == 16'd1) state_d = StCsum;
            end
          endcase
        end
      end
      StCsum: begin
        if (accept) state_d = (bus.in_data == csum_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase

    // A stalled stream abandons the load; any partial word is dropped.
    if (busy && !accept && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      len_lo_q <= 8'd0;
      rem_q    <= 16'd0;
      bcnt_q   <= 2'd0;
      asm_q    <= 24'd0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      csum_q   <= 8'd0;
      tmo_q    <= 32'd0;
      words_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      words_q  <= words_d;
    end
  end

endmodule

// File: tb/tb_rv_boot_loader.sv
// Scoreboard bench for rv_boot_loader: frame-level reference model queues expected writes,
// a negedge monitor compares them, and each frame's outcome is checked against the model.
module tb_rv_boot_loader;
  localparam int unsigned AW   = 10;
  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        core_rst, busy, done, error;
  logic [15:0] words_loaded;

  rv_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  rv_boot_loader #(
    .ADDR_WIDTH    (AW),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus.slave),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.mem_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        chk("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  // Frame-level model: how many bytes get consumed, which words land where, and the verdict.
  task automatic model(input byte unsigned f[$], output int n_use, output bit ok,
                       output int nwords);
    int   len;
    int   sum;
    wr_t  w;
    len = int'(f[0]) + 256 * int'(f[1]);
    if (len > int'(MAXW)) begin
      n_use  = 2;
      ok     = 1'b0;
      nwords = 0;
      return;
    end
    sum = 0;
    for (int i = 0; i < 2 + 4 * len; i++) sum += int'(f[i]);
    for (int k = 0; k < len; k++) begin
      w.addr = AW'(k);
      w.data = {f[5 + 4*k], f[4 + 4*k], f[3 + 4*k], f[2 + 4*k]};
      exp_q.push_back(w);
    end
    n_use  = 3 + 4 * len;
    ok     = ((sum % 256) == int'(f[2 + 4 * len]));
    nwords = len;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Entered and left at posedge+1 with in_valid low.
  task automatic send_byte(input byte unsigned b, input int gap);
    int g;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    g = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (bus.in_ready !== 1'b1) chk("ready_wait_expired", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input byte unsigned f[$], input int gmin,
                           input int gmax, input bit mid_start);
    int n_use;
    bit ok;
    int nw;
    model(f, n_use, ok, nw);
    pulse_start();
    for (int i = 0; i < n_use; i++) begin
      if (mid_start && i == 4) start = 1'b1;
      send_byte(f[i], int'($urandom_range(gmax, gmin)));
      start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done"},     32'(done),         32'(ok));
    chk({tag, "_error"},    32'(error),        32'(!ok));
    chk({tag, "_core_rst"}, 32'(core_rst),     32'(!ok));
    chk({tag, "_words"},    32'(words_loaded), 32'(nw));
    chk({tag, "_ready"},    32'(bus.in_ready), 32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_drained"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_rst"}, 32'(core_rst),      32'd1);
    chk({tag, "_ready"},    32'(bus.in_ready),  32'd0);
    chk({tag, "_we"},       32'(bus.mem_we),    32'd0);
    chk({tag, "_addr"},     32'(bus.mem_addr),  32'd0);
    chk({tag, "_wdata"},    bus.mem_wdata,      32'd0);
    chk({tag, "_busy"},     32'(busy),          32'd0);
    chk({tag, "_done"},     32'(done),          32'd0);
    chk({tag, "_error"},    32'(error),         32'd0);
    chk({tag, "_words"},    32'(words_loaded),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned nominal[$];
    byte unsigned f[$];
    int           len;
    int           sum;

    nominal = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
    rst          = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    run_frame("nominal", nominal, 0, 0, 1'b0);

    f = nominal;
    f[10] = 8'hB9;
    run_frame("bad_csum", f, 0, 0, 1'b0);
    run_frame("reload", nominal, 0, 0, 1'b0);

    f = '{8'h01, 8'h04};
    run_frame("oversize", f, 0, 0, 1'b0);
    f = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", f, 0, 0, 1'b0);

    run_frame("gaps", nominal, 3, 3, 1'b1);

    // Stall after three bytes; nothing may be written.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    repeat (TMO + 3) @(posedge clk);
    @(negedge clk);
    chk("timeout_error",    32'(error),    32'd1);
    chk("timeout_busy",     32'(busy),     32'd0);
    chk("timeout_core_rst", 32'(core_rst), 32'd1);

    // Reset between edges after six bytes, with the first word's write in flight.
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(nominal[i], 0);
    #1 rst = 1'b0;
    #1 check_reset_values("midreset");
    #10 rst = 1'b1;
    run_frame("after_reset", nominal, 0, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      len = int'($urandom_range(5, 1));
      f   = {};
      f.push_back(8'(len));
      f.push_back(8'h00);
      for (int i = 0; i < 4 * len; i++) f.push_back(8'($urandom));
      sum = 0;
      foreach (f[i]) sum += int'(f[i]);
      if ($urandom_range(3, 0) == 0) sum += int'($urandom_range(255, 1));
      f.push_back(8'(sum));
      run_frame("random", f, 0, 4, 1'($urandom));
    end

    repeat (5) @(posedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_boot_loader.md
Name: rv_boot_loader

Overview:
Byte-stream program loader that sits directly upstream of the multi-cycle core (rv_mc) and its unified memory. It receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words. It writes those words into instruction/data memory from word address 0 and holds the core in reset until a complete, checksum-verified image has been written. This is the synthesizable replacement for loading memory by file at simulation start.

Parameters:
ADDR_WIDTH, 10, memory word-address width.
MAX_WORDS, 1024, largest accepted image in words; must be ≤ 2**ADDR_WIDTH.
TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while loading; counter is 32 bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 resets the block.
start  input  1  single-cycle request to begin a load.
in_valid  input  1  byte present on in_data.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte; transfer occurs when in_valid & in_ready at a rising clk.
mem_we  output  1  one-cycle memory write strobe.
mem_addr  output  ADDR_WIDTH  word address of the write.
mem_wdata  output  32  word to write.
core_rst  output  1  active-high reset to rv_mc.
busy  output  1  load in progress.
done  output  1  last load succeeded.
error  output  1  last load failed.
words_loaded  output  16  words written by the current or last load.

Behaviour:
- Reset (rst=0, asynchronous) sets the following; memory contents are untouched:
  - state=IDLE, core_rst=1, in_ready=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_loaded=0, checksum accumulator=0, timeout counter=0.
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count, little-endian.
  - Then LEN words, 4 bytes each, least-significant byte first.
  - Then 1 CSUM byte, which must equal the sum mod 256 of all preceding frame bytes (length bytes included).
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
- in_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM.
- busy=1 in those same states.
- In IDLE, DONE and ERROR, start=1 does all of the following:
  - goes to LEN_LO and sets core_rst=1 on the next edge;
  - clears done, error, words_loaded, the accumulator and the timeout counter;
  - resets the write pointer to 0.
- start is ignored while busy.
- LEN_LO → LEN_HI on accept.
- On the LEN_HI accept, with L = {LEN_HI, LEN_LO}:
  - L > MAX_WORDS → ERROR.
  - L == 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - A byte counter 0..3 places each accepted byte into bits [8k+7:8k] of the assembly register.
  - On the 4th byte accepted at edge N, during cycle N+1: mem_we=1, mem_addr=pointer, mem_wdata=assembled word.
  - After that write, words_loaded and the pointer increment.
  - After word L has been accepted → CSUM.
  - in_ready stays 1 during the write cycle, so there is no bubble.
- CSUM: on accept, compare the byte with the accumulator.
  - Match → DONE: core_rst=0 and done=1 from the next cycle.
  - Mismatch → ERROR.
- ERROR: error=1, core_rst=1, in_ready=0; held until start or reset.
- The accumulator adds every accepted byte except the CSUM byte (8-bit, wraps).
- Timeout:
  - While busy, the counter increments each cycle without an accepted byte and clears on accept.
  - Reaching TIMEOUT_CYCLES → ERROR.
  - A partially assembled word is discarded; words already written remain in memory.
- Reset mid-load: immediate return to the reset values; core stays in reset.
- mem_we is never asserted outside DATA-originated writes.
- The pointer never exceeds MAX_WORDS-1 because L is bounded.

Test Plan:
1. Nominal load:
   - Stimulus: start, then bytes 02 00 13 00 00 00 93 00 10 00 B8, in_valid held high.
   - Required: mem_we pulses with addr 0 / 0x00000013 and addr 1 / 0x00100093.
   - Required: core_rst falls and done=1 the cycle after B8 is accepted; words_loaded=2.
2. Bad checksum:
   - Stimulus: same frame ending B9.
   - Required: error=1, done=0, core_rst stays 1, in_ready=0.
   - Required: a following start plus the correct frame yields done=1.
3. Oversize and empty:
   - Stimulus: LEN bytes 01 04 (1025).
   - Required: ERROR after the second byte, and no mem_we.
   - Stimulus: LEN bytes 00 00, then CSUM 00.
   - Required: done=1, words_loaded=0, and no mem_we.
4. Backpressure/gaps:
   - Stimulus: the nominal frame with in_valid dropping for 3 cycles between every byte.
   - Required: identical writes and result; start pulsed mid-load is ignored.
5. Timeout:
   - Stimulus: TIMEOUT_CYCLES=20; send 02 00 13 then stall 20 cycles.
   - Required: error=1, and no write to addr 0.
6. Async reset mid-DATA:
   - Stimulus: drop rst between clock edges after 6 bytes.
   - Required: outputs return to reset values immediately, core_rst=1, and the next frame loads from addr 0.
